mul_product_accumulator: RTL and testbench
==========================================

Name: mul_product_accumulator

Overview:
- Downstream consumer of the unsigned multiplier's product stream.
- Sums a framed sequence of products, with frames delimited by prod_last, into an ACC_WIDTH-bit result.
- Queues finished results in a small FIFO with a valid/ready output handshake.
- Sits between the multiplier pipeline, which cannot stall, and the result consumer. Any backpressure is absorbed by the FIFO, and results that arrive when it is full are reported as drops.

Parameters:
- PROD_WIDTH, 8: product width; equals 2*BITWIDTH_INPUT of the feeding multiplier.
- ACC_WIDTH, 16: accumulator and result width; must be >= PROD_WIDTH.
- CNT_WIDTH, 8: width of the per-frame term counter.
- FIFO_DEPTH, 4: result FIFO entries; a power of 2, >= 2.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rstn, input, 1: synchronous active-low reset.
- prod_valid, input, 1: prod is valid this cycle. There is no ready signal; the upstream pipeline never stalls.
- prod_last, input, 1: the current product closes the frame; qualified by prod_valid.
- prod, input, PROD_WIDTH: unsigned product.
- res_valid, output, 1: the FIFO head is valid.
- res_ready, input, 1: the consumer accepts the head.
- res_data, output, ACC_WIDTH: accumulated frame sum.
- res_terms, output, CNT_WIDTH: number of products in the frame; saturates at all-ones.
- res_ovf, output, 1: the frame sum exceeded ACC_WIDTH bits.
- drop_err, output, 1: sticky; a finished result was lost because the FIFO was full.
- busy, output, 1: a frame is open (at least one beat seen, last not yet seen).

Behaviour:
- Reset (rstn=0 at a clk edge) clears:
  - the accumulator and term counter; first-beat flag set to 1;
  - frame ovf, FIFO pointers and count, and drop_err;
  - outputs res_valid=0, busy=0, drop_err=0.
  - res_data, res_terms and res_ovf are don't-care while res_valid=0.
  - Reset mid-frame discards the partial sum; reset wins over every simultaneous event.
- Accumulate, on each prod_valid beat:
  - base = first ? 0 : acc;
  - sum = base + zero-extend(prod), computed at ACC_WIDTH+1 bits;
  - acc <= sum[ACC_WIDTH-1:0], i.e. the sum wraps modulo 2^ACC_WIDTH;
  - frame ovf <= (first ? 0 : ovf) | sum[ACC_WIDTH];
  - terms <= (first ? 1 : terms+1), saturating at 2^CNT_WIDTH-1;
  - first <= prod_last.
- A beat with prod_valid=0 changes nothing; idle gaps inside a frame are legal.
- Frame close, when prod_valid=1 and prod_last=1:
  - Push {sum[ACC_WIDTH-1:0], final terms, final ovf} into the FIFO in the same cycle.
  - A single-beat frame (first=1, last=1) yields res_data=prod, res_terms=1, res_ovf=0.
- busy = !first.
- FIFO:
  - Registered write, combinational head read.
  - res_valid = (count != 0). Entries are popped when res_valid & res_ready.
  - A result pushed into an empty FIFO is visible on res_valid in the cycle after the closing beat. Latency from the last beat to res_valid is exactly 1 cycle.
  - The head is held stable while res_valid=1 and res_ready=0.
- Full-FIFO and simultaneous events:
  - Full and push without pop: the result is dropped, the FIFO is unchanged, and drop_err is set and stays 1 until reset. Accumulator state still closes the frame, so first=1.
  - Full with push and pop in the same cycle: the pop frees a slot and the push is accepted; count stays FIFO_DEPTH; no drop.
  - Push and pop on a non-full, non-empty FIFO: count is unchanged.
  - res_ready while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: MUL_ACC_SATURATE_EN.
- Defined: when the (ACC_WIDTH+1)-bit sum has its top bit set, acc is set to all-ones. Later beats in the frame keep it at all-ones because the saturating add is sticky. res_ovf still reports the event.
- Undefined: wrap-around as described in Behaviour.

Test Plan:
- Reset, then frame 3,5,7 with last on 7 -> one cycle later res_valid=1, res_data=15, res_terms=3, res_ovf=0, busy=0.
- Single beat prod=200, last=1 -> res_data=200, res_terms=1.
- Two frames back-to-back (10,last; 20,30,last) with idle gaps and res_ready=1 -> results 10 then 50, in order.
- ACC_WIDTH=16, frame of 255 beats of 255 plus one beat of 2000 -> res_data=(65025+2000) mod 65536=1489, res_ovf=1; with MUL_ACC_SATURATE_EN, res_data=65535.
- res_ready=0, five single-beat frames 1..5 with FIFO_DEPTH=4 -> FIFO holds 1..4, drop_err=1; then drain gives 1,2,3,4 and drop_err stays 1.
- Reset asserted after beats 9,9 without last, then frame 4,last -> res_data=4, res_terms=1; no stale result from the aborted frame appears.

Source files
------------

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
//
// Sums framed product beats from the multiplier pipeline, one sum per frame.
// prod_last closes a frame. Each finished frame sum is queued in a small result
// FIFO. The upstream side cannot stall, so a result that arrives while the FIFO
// is full is discarded, and the sticky drop_err flag records the loss.
//
// Ports:
//   clk         rising-edge clock
//   rstn        synchronous active-low reset
//   prod_valid  product beat valid (there is no ready; upstream never stalls)
//   prod_last   beat closes the current frame (qualified by prod_valid)
//   prod        unsigned product, PROD_WIDTH bits
//   res_valid   FIFO head is valid
//   res_ready   consumer accepts the head
//   res_data    frame sum, ACC_WIDTH bits
//   res_terms   number of beats in the frame, saturating at all-ones
//   res_ovf     frame sum carried out of ACC_WIDTH bits at least once
//   drop_err    sticky: a finished result was lost to a full FIFO
//   busy        a frame is open
//
// Build option:
//   MUL_ACC_SATURATE_EN  when defined, the accumulator clamps to all-ones on
//                        carry-out instead of wrapping.
module mul_product_accumulator #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  prod_valid,
    input  logic                  prod_last,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic [CNT_WIDTH-1:0]  res_terms,
    output logic                  res_ovf,
    output logic                  drop_err,
    output logic                  busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int ENTRY_W = ACC_WIDTH + CNT_WIDTH + 1;

    // ---------------- accumulator ----------------
    logic [ACC_WIDTH-1:0] acc_reg,   acc_next;
    logic [CNT_WIDTH-1:0] terms_reg, terms_next;
    logic                 ovf_reg,   ovf_next;
    logic                 first_reg, first_next;

    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_beat;
    logic [CNT_WIDTH-1:0] terms_beat;
    logic                 ovf_beat;

    always_comb begin
        // The first beat of a frame starts from zero, not from the previous frame.
        base = first_reg ? '0 : acc_reg;
        sum  = {1'b0, base} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod};
`ifdef MUL_ACC_SATURATE_EN
        // Once clamped, acc is all-ones. Adding any nonzero product carries
        // again, and adding zero leaves it unchanged, so the clamp holds.
        acc_beat = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc_beat = sum[ACC_WIDTH-1:0];
`endif
        ovf_beat   = (first_reg ? 1'b0 : ovf_reg) | sum[ACC_WIDTH];
        terms_beat = first_reg ? CNT_WIDTH'(1)
                   : ((&terms_reg) ? terms_reg : terms_reg + 1'b1);

        acc_next   = acc_reg;
        terms_next = terms_reg;
        ovf_next   = ovf_reg;
        first_next = first_reg;
        if (prod_valid) begin
            acc_next   = acc_beat;
            terms_next = terms_beat;
            ovf_next   = ovf_beat;
            first_next = prod_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_reg   <= '0;
            terms_reg <= '0;
            ovf_reg   <= 1'b0;
            first_reg <= 1'b1;
        end else begin
            acc_reg   <= acc_next;
            terms_reg <= terms_next;
            ovf_reg   <= ovf_next;
            first_reg <= first_next;
        end
    end

    assign busy = ~first_reg;

    // ---------------- result FIFO ----------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [FCNT_W-1:0]  count_reg,  count_next;
    logic               drop_reg,   drop_next;

    logic               push, pop, full, wr_en;
    logic [ENTRY_W-1:0] entry_in;

    // The closing beat's own sum goes into the FIFO in the same cycle.
    // It does not wait for the accumulator registers to update.
    assign entry_in = {acc_beat, terms_beat, ovf_beat};
    assign push     = prod_valid & prod_last;
    assign pop      = res_valid & res_ready;
    assign full     = (count_reg == FCNT_W'(FIFO_DEPTH));
    // A same-cycle pop frees the slot, so a push into a full FIFO is kept then.
    assign wr_en    = push & (~full | pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        drop_next   = drop_reg | (push & ~wr_en);
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;   // power-of-2 depth: natural wrap
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            drop_reg   <= drop_next;
        end
    end

    // Storage needs no reset. Contents are only observed while count is nonzero.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                mem[gi] <= entry_in;
            end
        end
    end

    assign res_valid = (count_reg != '0);
    assign {res_data, res_terms, res_ovf} = mem[rd_ptr_reg];
    assign drop_err  = drop_reg;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Testbench for mul_product_accumulator. It uses directed scenarios plus
// randomized traffic, and compares the outputs against a frame-level model:
// the true frame sum as a wide integer, and a queue that stands in for the
// result FIFO.
module tb_mul_product_accumulator;
    localparam int PW = 12;
    localparam int AW = 16;
    localparam int CW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          prod_valid = 1'b0, prod_last = 1'b0, res_ready = 1'b0;
    logic [PW-1:0] prod = '0;
    logic          res_valid, res_ovf, drop_err, busy;
    logic [AW-1:0] res_data;
    logic [CW-1:0] res_terms;

    always #5 clk = ~clk;

    mul_product_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn), .prod_valid(prod_valid), .prod_last(prod_last), .prod(prod),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_terms(res_terms),
        .res_ovf(res_ovf), .drop_err(drop_err), .busy(busy));

    typedef struct { logic [AW-1:0] data; logic [CW-1:0] terms; logic ovf; } res_t;
    res_t    q[$];
    longint  m_sum;
    int      m_n;
    bit      m_open, m_drop;
    int      passed = 0, total = 0;

    function automatic res_t make_res();
        res_t r;
        r.ovf   = (m_sum > longint'(2**AW - 1));
        r.terms = (m_n > 2**CW - 1) ? CW'(2**CW - 1) : CW'(m_n);
`ifdef MUL_ACC_SATURATE_EN
        r.data  = r.ovf ? '1 : AW'(m_sum % (2**AW));
`else
        r.data  = AW'(m_sum % (2**AW));
`endif
        return r;
    endfunction

    // Drives one clock cycle and advances the model. Outputs are stable 1 time unit after the edge.
    task automatic cycle(input bit v, input bit l, input int p, input bit r);
        bit pop;
        prod_valid = v; prod_last = l; prod = PW'(p); res_ready = r;
        @(posedge clk);
        pop = r && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (v) begin
            if (!m_open) begin m_sum = 0; m_n = 0; end
            m_sum += p; m_n++;
            m_open = !l;
            if (l) begin
                if (q.size() < FD) q.push_back(make_res());
                else m_drop = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; prod_valid = 1'b1; prod_last = 1'b1; prod = PW'($urandom); res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; res_ready = 1'b0;
        q.delete(); m_open = 0; m_drop = 0; m_sum = 0; m_n = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", res_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        total++; if (drop_err !== 1'b0) $display("FAIL reset_drop: got %0b want 0", drop_err); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        cycle(1, 0, 3, 0);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_open: got %0b want 1", busy); else passed++;
        cycle(1, 0, 5, 0);
        total++; if (res_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b want 0", res_valid); else passed++;
        cycle(1, 1, 7, 0);
        total++; if (res_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", res_valid); else passed++;
        total++; if (res_data !== 16'd15) $display("FAIL basic_data: got %0d want 15", res_data); else passed++;
        total++; if (res_terms !== 8'd3) $display("FAIL basic_terms: got %0d want 3", res_terms); else passed++;
        total++; if (res_ovf !== 1'b0) $display("FAIL basic_ovf: got %0b want 0", res_ovf); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %0b want 0", busy); else passed++;
        cycle(0, 0, 0, 1);
        total++; if (res_valid !== 1'b0) $display("FAIL basic_pop: got %0b want 0", res_valid); else passed++;
        $display("test_basic_frame done");
    endtask

    task automatic test_single_beat();
        cycle(1, 1, 200, 0);
        cycle(0, 0, 0, 0);  // head must hold while not accepted
        total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", res_valid); else passed++;
        total++; if (res_data !== 16'd200) $display("FAIL single_data: got %0d want 200", res_data); else passed++;
        total++; if (res_terms !== 8'd1) $display("FAIL single_terms: got %0d want 1", res_terms); else passed++;
        total++; if (res_ovf !== 1'b0) $display("FAIL single_ovf: got %0b want 0", res_ovf); else passed++;
        cycle(0, 0, 0, 1);
        $display("test_single_beat done");
    endtask

    task automatic test_back_to_back();
        int seq_v[8] = '{1, 0, 0, 1, 0, 1, 0, 0};
        int seq_l[8] = '{1, 0, 0, 0, 0, 1, 0, 0};
        int seq_p[8] = '{10, 0, 0, 20, 0, 30, 0, 0};
        int want[2]  = '{10, 50};
        int idx = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(seq_v[i] != 0, seq_l[i] != 0, seq_p[i], 1);
            if (res_valid === 1'b1) begin
                total++;
                if (idx >= 2) $display("FAIL b2b_extra: got %0d want none", res_data);
                else if (res_data !== AW'(want[idx])) $display("FAIL b2b_data%0d: got %0d want %0d", idx, res_data, want[idx]);
                else passed++;
                idx++;
            end
        end
        total++; if (idx != 2) $display("FAIL b2b_count: got %0d want 2", idx); else passed++;
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        logic [AW-1:0] want;
`ifdef MUL_ACC_SATURATE_EN
        want = 16'd65535;
`else
        want = 16'd1489;
`endif
        for (int i = 0; i < 255; i++) cycle(1, 0, 255, 0);
        cycle(1, 1, 2000, 0);
        total++; if (res_data !== want) $display("FAIL ovf_data: got %0d want %0d", res_data, want); else passed++;
        total++; if (res_terms !== 8'd255) $display("FAIL ovf_terms: got %0d want 255", res_terms); else passed++;
        total++; if (res_ovf !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", res_ovf); else passed++;
        cycle(0, 0, 0, 1);
        $display("test_overflow done");
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 1; k <= 5; k++) cycle(1, 1, k, 0);
        total++; if (drop_err !== 1'b1) $display("FAIL full_drop: got %0b want 1", drop_err); else passed++;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== AW'(k)) $display("FAIL full_drain%0d: got v=%0b d=%0d want v=1 d=%0d", k, res_valid, res_data, k);
            else passed++;
            cycle(0, 0, 0, 1);
        end
        total++; if (res_valid !== 1'b0) $display("FAIL full_empty: got %0b want 0", res_valid); else passed++;
        total++; if (drop_err !== 1'b1) $display("FAIL full_sticky: got %0b want 1", drop_err); else passed++;
        $display("test_fifo_full done");
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 10; k <= 13; k++) cycle(1, 1, k, 0);
        cycle(1, 1, 14, 1);  // push and pop while full
        total++; if (drop_err !== 1'b0) $display("FAIL pushpop_drop: got %0b want 0", drop_err); else passed++;
        for (int k = 11; k <= 14; k++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== AW'(k)) $display("FAIL pushpop_drain%0d: got v=%0b d=%0d want v=1 d=%0d", k, res_valid, res_data, k);
            else passed++;
            cycle(0, 0, 0, 1);
        end
        total++; if (res_valid !== 1'b0) $display("FAIL pushpop_empty: got %0b want 0", res_valid); else passed++;
        $display("test_full_push_pop done");
    endtask

    task automatic test_reset_midframe();
        cycle(1, 0, 9, 0);
        cycle(1, 0, 9, 0);
        do_reset();
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else passed++;
        cycle(1, 1, 4, 0);
        total++; if (res_data !== 16'd4) $display("FAIL midrst_data: got %0d want 4", res_data); else passed++;
        total++; if (res_terms !== 8'd1) $display("FAIL midrst_terms: got %0d want 1", res_terms); else passed++;
        cycle(0, 0, 0, 1);
        total++; if (res_valid !== 1'b0) $display("FAIL midrst_stale: got %0b want 0", res_valid); else passed++;
        $display("test_reset_midframe done");
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                bit v = ($urandom % 4) != 0;
                bit l = (ph == 1) ? (($urandom % 25) == 0) : (($urandom % 5) == 0);
                bit r = (ph == 2) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
                cycle(v, l, int'($urandom % (2**PW)), r);
                total++;
                if (res_valid !== (q.size() != 0)) begin
                    errs++; $display("FAIL rnd_valid c%0d: got %0b want %0b", i, res_valid, q.size() != 0);
                end else if (q.size() != 0 && (res_data !== q[0].data || res_terms !== q[0].terms || res_ovf !== q[0].ovf)) begin
                    errs++; $display("FAIL rnd_head c%0d: got %0d/%0d/%0b want %0d/%0d/%0b", i, res_data, res_terms, res_ovf, q[0].data, q[0].terms, q[0].ovf);
                end else if (busy !== m_open || drop_err !== m_drop) begin
                    errs++; $display("FAIL rnd_flags c%0d: got busy=%0b drop=%0b want busy=%0b drop=%0b", i, busy, drop_err, m_open, m_drop);
                end else passed++;
                if (errs > 20) break;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_fifo_full();
        test_full_push_pop();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
